// File: rtl/blk_row_feeder.sv
// blk_row_feeder: fetches one 4x4 pixel block from frame memory, one row word per
// read, and streams the four rows top-first as a contiguous 4-cycle row_valid burst
// into the row-load port of the PE block register.
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   start           request a block fetch, honoured only while busy=0
//   blk_base_addr   address of the block's top row word, sampled with start
//   busy            fetch in progress (from accept until the cycle after done)
//   done            1-cycle pulse coincident with the 4th row_valid
//   mem_rd_en       frame memory read strobe
//   mem_rd_addr     frame memory read address (holds its last value outside reads)
//   mem_rd_data     read data, valid RD_LAT edges after the read is sampled
//   row_data        row word, column 0 in the MSBs; holds outside a burst
//   row_valid       row_data valid (load enable of the block register)
module blk_row_feeder #(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ROW_PITCH  = 16,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   blk_base_addr,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
  input  logic [WORD_WIDTH*4-1:0] mem_rd_data,
  output logic [WORD_WIDTH*4-1:0] row_data,
  output logic                    row_valid
);

  localparam logic [ADDR_WIDTH-1:0] Pitch = ADDR_WIDTH'(ROW_PITCH);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              rd_cnt_q;
  logic [1:0]              row_cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [RD_LAT-1:0]       pend_q;
  logic [WORD_WIDTH*4-1:0] row_data_q;
  logic                    row_valid_q;
  logic                    done_q;
  logic                    accept;
  logic                    capture;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start)            state_d = StRead;
      StRead:  if (rd_cnt_q == 2'd3) state_d = StDrain;
      // done_q marks the 4th row on the port; leave the cycle after it.
      StDrain: if (done_q)           state_d = StIdle;
      default:                       state_d = StIdle;
    endcase
  end

  // Outputs: decoded from flops only, never from inputs
  always_comb begin
    busy        = (state_q != StIdle);
    mem_rd_en   = (state_q == StRead);
    mem_rd_addr = addr_q;
    row_data    = row_data_q;
    row_valid   = row_valid_q;
    done        = done_q;
  end

  assign accept  = (state_q == StIdle) && start;
  // Oldest outstanding read has data on mem_rd_data this cycle.
  assign capture = pend_q[RD_LAT-1];

  // Read address and read counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q   <= '0;
      rd_cnt_q <= 2'd0;
    end else if (accept) begin
      addr_q   <= blk_base_addr;
      rd_cnt_q <= 2'd0;
    end else if (mem_rd_en) begin
      rd_cnt_q <= rd_cnt_q + 2'd1;
      // Stop stepping after the last row so the address holds at row 3; wraps mod 2^N.
      if (rd_cnt_q != 2'd3) begin
        addr_q <= addr_q + Pitch;
      end
    end
  end

  // Outstanding-read tracker, one stage per edge of memory latency
  generate
    if (RD_LAT == 1) begin : g_pend_one
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          pend_q <= '0;
        end else begin
          pend_q <= mem_rd_en;
        end
      end
    end else begin : g_pend_multi
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          pend_q <= '0;
        end else begin
          pend_q <= {pend_q[RD_LAT-2:0], mem_rd_en};
        end
      end
    end
  endgenerate

  // Row capture, valid and done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_data_q  <= '0;
      row_valid_q <= 1'b0;
      done_q      <= 1'b0;
      row_cnt_q   <= 2'd0;
    end else begin
      row_valid_q <= capture;
      done_q      <= capture && (row_cnt_q == 2'd3);
      if (capture) begin
        row_data_q <= mem_rd_data;
        row_cnt_q  <= row_cnt_q + 2'd1;
      end
    end
  end

endmodule
